// File: rtl/clock_period_meter.sv
// Measures a divided clock (clk_in_i, synchronous to clk) in clk cycles: period, high/low time,
// lock on a stable period and timeout when the input stops toggling.
module clock_period_meter #(
  parameter int unsigned N          = 8,
  parameter int unsigned LOCK_COUNT = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clk_in_i,
  output logic [N-1:0] period_o,
  output logic [N-1:0] high_time_o,
  output logic [N-1:0] low_time_o,
  output logic         meas_valid_o,
  output logic         locked_o,
  output logic         timeout_o
);

  localparam logic [N-1:0] CntMax  = '1;
  localparam logic [N-1:0] CntOne  = N'(1);
  localparam logic [3:0]   LockCnt = 4'(LOCK_COUNT);

  typedef enum logic [0:0] {StWaitFirst, StMeasure} state_e;

  state_e       state_q;
  logic         in_d_q;
  logic [N-1:0] cnt_q, cnt_d;
  logic [N-1:0] high_r_q;
  logic [N-1:0] prev_period_q;
  logic [3:0]   match_q, match_d;
  logic         rise, fall;

  assign rise = clk_in_i & ~in_d_q;
  assign fall = ~clk_in_i & in_d_q;

  always_comb begin
    cnt_d = cnt_q;
    if (rise) begin
      cnt_d = CntOne;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + CntOne;
    end
  end

  // A zero match count marks the first measurement after reset or timeout.
  always_comb begin
    match_d = 4'd1;
    if (match_q != 4'd0 && cnt_q == prev_period_q) begin
      match_d = (match_q >= LockCnt) ? LockCnt : match_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StWaitFirst;
      in_d_q        <= 1'b1;
      cnt_q         <= '0;
      high_r_q      <= '0;
      prev_period_q <= '0;
      match_q       <= 4'd0;
      period_o      <= '0;
      high_time_o   <= '0;
      low_time_o    <= '0;
      meas_valid_o  <= 1'b0;
      locked_o      <= 1'b0;
      timeout_o     <= 1'b0;
    end else begin
      in_d_q       <= clk_in_i;
      cnt_q        <= cnt_d;
      meas_valid_o <= 1'b0;
      case (state_q)
        StWaitFirst: begin
          if (rise) begin
            state_q   <= StMeasure;
            timeout_o <= 1'b0;
          end
        end
        StMeasure: begin
          if (rise) begin
            period_o      <= cnt_q;
            high_time_o   <= high_r_q;
            low_time_o    <= cnt_q - high_r_q;
            meas_valid_o  <= 1'b1;
            prev_period_q <= cnt_q;
            match_q       <= match_d;
            locked_o      <= (match_d >= LockCnt);
          end else if (cnt_q == CntMax) begin
            timeout_o <= 1'b1;
            locked_o  <= 1'b0;
            match_q   <= 4'd0;
            state_q   <= StWaitFirst;
          end else if (fall) begin
            high_r_q <= cnt_q;
          end
        end
        default: state_q <= StWaitFirst;
      endcase
    end
  end

endmodule

// File: tb/tb_clock_period_meter.sv
// Directed self-checking bench for clock_period_meter (N=8, LOCK_COUNT=2).
module tb_clock_period_meter;

  logic       clk;
  logic       rst_n;
  logic       clk_in;
  logic [7:0] period, high_time, low_time;
  logic       meas_valid, locked, timeout;

  int checks = 0;
  int errors = 0;

  // Values captured one cycle after each driven rise, plus stray valid pulses in the rest.
  logic       cap_mv, cap_lk, cap_to;
  logic [7:0] cap_p, cap_h, cap_l;
  int         extra_mv;

  clock_period_meter #(.N(8), .LOCK_COUNT(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clk_in_i     (clk_in),
    .period_o     (period),
    .high_time_o  (high_time),
    .low_time_o   (low_time),
    .meas_valid_o (meas_valid),
    .locked_o     (locked),
    .timeout_o    (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wave_cycle(input int hi, input int lo);
    extra_mv = 0;
    clk_in = 1'b1;
    tick();
    cap_mv = meas_valid; cap_lk = locked; cap_to = timeout;
    cap_p = period; cap_h = high_time; cap_l = low_time;
    for (int i = 1; i < hi; i++) begin
      tick();
      if (meas_valid) extra_mv++;
    end
    clk_in = 1'b0;
    for (int i = 0; i < lo; i++) begin
      tick();
      if (meas_valid) extra_mv++;
    end
  endtask

  task automatic check_meas(input string name, input logic [7:0] p, input logic [7:0] h,
                            input logic [7:0] l, input logic lk);
    checks++;
    if ({cap_mv, cap_p, cap_h, cap_l, cap_lk} !== {1'b1, p, h, l, lk} || extra_mv != 0) begin
      errors++;
      $display("FAIL %s: got mv=%0b p=%0d h=%0d l=%0d lk=%0b extra=%0d, want mv=1 p=%0d h=%0d l=%0d lk=%0b extra=0",
               name, cap_mv, cap_p, cap_h, cap_l, cap_lk, extra_mv, p, h, l, lk);
    end
  endtask

  task automatic test_reset();
    int stray;
    rst_n = 1'b0;
    clk_in = 1'b1;
    #1;
    checks++;
    if ({period, high_time, low_time, meas_valid, locked, timeout} !== 27'd0) begin
      errors++;
      $display("FAIL reset_outputs: got p=%0d h=%0d l=%0d mv=%0b lk=%0b to=%0b, want all 0",
               period, high_time, low_time, meas_valid, locked, timeout);
    end
    tick(); tick();
    rst_n = 1'b1;
    stray = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (meas_valid || timeout) stray++;
    end
    clk_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (meas_valid || timeout) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL reset_high_no_edge: got %0d stray pulses, want 0", stray);
    end
    wave_cycle(3, 3);
    checks++;
    if (cap_mv !== 1'b0 || extra_mv != 0) begin
      errors++;
      $display("FAIL first_rise_no_meas: got mv=%0b extra=%0d, want mv=0 extra=0", cap_mv, extra_mv);
    end
    wave_cycle(3, 3);
    check_meas("meas1_p6", 8'd6, 8'd3, 8'd3, 1'b0);
    wave_cycle(3, 3);
    check_meas("meas2_p6_lock", 8'd6, 8'd3, 8'd3, 1'b1);
  endtask

  task automatic test_ratio_change();
    wave_cycle(4, 4);
    check_meas("rc_tail_p6", 8'd6, 8'd3, 8'd3, 1'b1);
    wave_cycle(4, 4);
    check_meas("rc_p8_unlock", 8'd8, 8'd4, 8'd4, 1'b0);
    wave_cycle(4, 4);
    check_meas("rc_p8_lock", 8'd8, 8'd4, 8'd4, 1'b1);
    wave_cycle(2, 2);
    check_meas("rc_p8_hold", 8'd8, 8'd4, 8'd4, 1'b1);
    wave_cycle(2, 2);
    check_meas("rc_p4_drop", 8'd4, 8'd2, 8'd2, 1'b0);
    wave_cycle(2, 2);
    check_meas("rc_p4_relock", 8'd4, 8'd2, 8'd2, 1'b1);
  endtask

  task automatic test_asymmetric();
    wave_cycle(2, 5);
    check_meas("asym_tail_p4", 8'd4, 8'd2, 8'd2, 1'b1);
    wave_cycle(2, 5);
    check_meas("asym_p7", 8'd7, 8'd2, 8'd5, 1'b0);
    wave_cycle(2, 5);
    check_meas("asym_p7_lock", 8'd7, 8'd2, 8'd5, 1'b1);
  endtask

  task automatic test_min_period();
    wave_cycle(1, 1);
    check_meas("min_tail_p7", 8'd7, 8'd2, 8'd5, 1'b1);
    wave_cycle(1, 1);
    check_meas("min_p2", 8'd2, 8'd1, 8'd1, 1'b0);
    wave_cycle(1, 1);
    check_meas("min_p2_lock", 8'd2, 8'd1, 8'd1, 1'b1);
  endtask

  task automatic test_timeout();
    int early;
    // Last rise, then hold low; timeout must appear 255 cycles after this rise is sampled.
    clk_in = 1'b1;
    tick();
    check_meas("to_last_p2", 8'd2, 8'd1, 8'd1, 1'b1);
    clk_in = 1'b0;
    early = 0;
    for (int i = 1; i < 255; i++) begin
      tick();
      if (timeout || !locked || meas_valid) early++;
    end
    checks++;
    if (early != 0) begin
      errors++;
      $display("FAIL timeout_early: got %0d bad cycles before 255, want 0", early);
    end
    tick();
    checks++;
    if ({timeout, locked, period, high_time, low_time} !== {1'b1, 1'b0, 8'd2, 8'd1, 8'd1}) begin
      errors++;
      $display("FAIL timeout_at_255: got to=%0b lk=%0b p=%0d h=%0d l=%0d, want to=1 lk=0 p=2 h=1 l=1",
               timeout, locked, period, high_time, low_time);
    end
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (timeout !== 1'b1) begin
      errors++;
      $display("FAIL timeout_sticky: got to=%0b, want 1", timeout);
    end
    wave_cycle(3, 3);
    checks++;
    if (cap_to !== 1'b0 || cap_mv !== 1'b0 || extra_mv != 0) begin
      errors++;
      $display("FAIL timeout_recover: got to=%0b mv=%0b extra=%0d, want to=0 mv=0 extra=0",
               cap_to, cap_mv, extra_mv);
    end
    wave_cycle(3, 3);
    check_meas("recover_p6", 8'd6, 8'd3, 8'd3, 1'b0);
  endtask

  task automatic test_reset_mid();
    int stray;
    wave_cycle(3, 3);
    check_meas("mid_pre_lock", 8'd6, 8'd3, 8'd3, 1'b1);
    clk_in = 1'b1;
    tick(); tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({period, high_time, low_time, meas_valid, locked, timeout} !== 27'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got p=%0d h=%0d l=%0d mv=%0b lk=%0b to=%0b, want all 0",
               period, high_time, low_time, meas_valid, locked, timeout);
    end
    tick();
    rst_n = 1'b1;
    stray = 0;
    tick();
    if (meas_valid) stray++;
    clk_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (meas_valid) stray++;
    end
    wave_cycle(3, 3);
    if (cap_mv) stray++;
    stray += extra_mv;
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL reset_mid_no_spurious: got %0d valid pulses, want 0", stray);
    end
    wave_cycle(3, 3);
    check_meas("post_reset_p6", 8'd6, 8'd3, 8'd3, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    clk_in = 1'b1;
    test_reset();
    test_ratio_change();
    test_asymmetric();
    test_min_period();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
